// File: rtl/gate_pkg.sv
// Shared gate-controller types: state encodings, light encodings, output payload.
package gate_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned LIGHT_W = 2;
  localparam int unsigned CNT_W   = 8;

  // Gate state encodings
  localparam logic [STATE_W-1:0] ST_INIT    = 3'd0;
  localparam logic [STATE_W-1:0] ST_OPEN    = 3'd1;
  localparam logic [STATE_W-1:0] ST_WARN    = 3'd2;
  localparam logic [STATE_W-1:0] ST_CLOSING = 3'd3;
  localparam logic [STATE_W-1:0] ST_CLOSED  = 3'd4;
  localparam logic [STATE_W-1:0] ST_OPENING = 3'd5;
  localparam logic [STATE_W-1:0] ST_FAULT   = 3'd6;

  typedef enum logic [STATE_W-1:0] {
    S_INIT    = ST_INIT,
    S_OPEN    = ST_OPEN,
    S_WARN    = ST_WARN,
    S_CLOSING = ST_CLOSING,
    S_CLOSED  = ST_CLOSED,
    S_OPENING = ST_OPENING,
    S_FAULT   = ST_FAULT
  } gate_state_e;

  // Light encodings shared with the traffic light FSM; 2'b11 reads as RED
  localparam logic [LIGHT_W-1:0] LIGHT_RED    = 2'b00;
  localparam logic [LIGHT_W-1:0] LIGHT_GREEN  = 2'b01;
  localparam logic [LIGHT_W-1:0] LIGHT_YELLOW = 2'b10;

  // Output payload decoded from the gate state
  typedef struct packed {
    logic motor_up;
    logic motor_down;
    logic gate_closed;
    logic warn;
    logic fault;
  } gate_out_t;

  // Anything that is neither GREEN nor YELLOW is treated as RED
  function automatic logic light_is_red(input logic [LIGHT_W-1:0] l);
    return !((l == LIGHT_GREEN) || (l == LIGHT_YELLOW));
  endfunction

endpackage

// File: rtl/gate_tick_cnt.sv
// Tick counter for timed gate states; done fires on the target-th tick.
module gate_tick_cnt
  import gate_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             tick,
  input  logic [CNT_W-1:0] target,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  // Count ticks while enabled; a clear (state change) takes priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && tick) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // N ticks elapsed: tick arrives while count == N-1
  assign done = en && tick && (cnt_q == (target - CNT_W'(1)));

endmodule

// File: rtl/gate_ctrl.sv
// Barrier-gate controller: opens on GREEN, closes on RED, holds on YELLOW,
// reverses on obstruction, latches FAULT on timeout or contradictory limits.
// Optional pre-close warning state enabled by defining GATE_WARN_EN.
module gate_ctrl
  import gate_pkg::*;
#(
  parameter int unsigned MOVE_TIMEOUT = 6,
  parameter int unsigned WARN_DUR     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [LIGHT_W-1:0] light_state,
  input  logic               lim_open,
  input  logic               lim_closed,
  input  logic               obstacle,
  input  logic               fault_clr,
  output logic               motor_up,
  output logic               motor_down,
  output logic               gate_closed,
  output logic               warn,
  output logic               fault,
  output logic [STATE_W-1:0] gate_state
);

  gate_state_e      state_q, state_d;
  gate_out_t        out_d, out_q;
  logic             is_red, is_green, timed, cnt_clr, elapsed;
  logic [CNT_W-1:0] target;

  // Light decode and timer selection for the current state
  always_comb begin
    is_red   = light_is_red(light_state);
    is_green = (light_state == LIGHT_GREEN);
    timed    = (state_q == S_WARN) || (state_q == S_CLOSING) || (state_q == S_OPENING);
    target   = (state_q == S_WARN) ? CNT_W'(WARN_DUR) : CNT_W'(MOVE_TIMEOUT);
    cnt_clr  = (state_d != state_q);
  end

  gate_tick_cnt u_tick_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .en     (timed),
    .tick   (tick),
    .target (target),
    .done   (elapsed)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, first matching rule wins
  always_comb begin
    state_d = state_q;
    if ((state_q != S_FAULT) && lim_open && lim_closed) begin
      state_d = S_FAULT;
    end else begin
      unique case (state_q)
        S_INIT:    state_d = lim_open ? S_OPEN : S_OPENING;
`ifdef GATE_WARN_EN
        S_OPEN:    if (is_red) state_d = S_WARN;
        S_WARN: begin
          if (!is_red)      state_d = S_OPEN;
          else if (elapsed) state_d = S_CLOSING;
        end
`else
        S_OPEN:    if (is_red) state_d = S_CLOSING;
`endif
        S_CLOSING: begin
          if (obstacle || is_green) state_d = S_OPENING;
          else if (lim_closed)      state_d = S_CLOSED;
          else if (elapsed)         state_d = S_FAULT;
        end
        S_CLOSED:  if (is_green) state_d = S_OPENING;
        S_OPENING: begin
          if (lim_open)     state_d = S_OPEN;
          else if (elapsed) state_d = S_FAULT;
        end
        S_FAULT:   if (fault_clr) state_d = S_INIT;
        default:   state_d = S_INIT;
      endcase
    end
  end

  // Output decode from next state so registered outputs track the state register
  always_comb begin
    out_d             = '0;
    out_d.motor_up    = (state_d == S_OPENING);
    out_d.motor_down  = (state_d == S_CLOSING);
    out_d.gate_closed = (state_d == S_CLOSED);
    out_d.fault       = (state_d == S_FAULT);
`ifdef GATE_WARN_EN
    out_d.warn        = (state_d == S_WARN);
`else
    out_d.warn        = 1'b0;
`endif
  end

  // Output register; async reset drops the motors immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign motor_up    = out_q.motor_up;
  assign motor_down  = out_q.motor_down;
  assign gate_closed = out_q.gate_closed;
  assign warn        = out_q.warn;
  assign fault       = out_q.fault;
  assign gate_state  = state_q;

endmodule

// File: tb/tb_gate_ctrl.sv
// Self-checking bench for gate_ctrl: behavioural model compared every cycle,
// directed scenarios pinning literal states, then randomized stimulus.
module tb_gate_ctrl;

  localparam int MOVE_TIMEOUT = 6;
  localparam int WARN_DUR     = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, lim_open, lim_closed, obstacle, fault_clr;
  logic [1:0] light_state;
  logic       motor_up, motor_down, gate_closed, warn, fault;
  logic [2:0] gate_state;

  int checks = 0;
  int passes = 0;

  // Literal pins set by the stimulus process, checked by the compare process
  logic       pin_valid = 1'b0;
  logic [2:0] pin_state = 3'd0;

  // Model state: gate position label and ticks seen since entering it
  int m_state;
  int m_ticks;

  gate_ctrl #(.MOVE_TIMEOUT(MOVE_TIMEOUT), .WARN_DUR(WARN_DUR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .light_state (light_state),
    .lim_open    (lim_open),
    .lim_closed  (lim_closed),
    .obstacle    (obstacle),
    .fault_clr   (fault_clr),
    .motor_up    (motor_up),
    .motor_down  (motor_down),
    .gate_closed (gate_closed),
    .warn        (warn),
    .fault       (fault),
    .gate_state  (gate_state)
  );

  always #5 clk = ~clk;

  // 0 INIT, 1 OPEN, 2 WARN, 3 CLOSING, 4 CLOSED, 5 OPENING, 6 FAULT
  function automatic int model_next(input int s, input int t, input logic [1:0] light,
                                    input logic lo, input logic lc, input logic ob,
                                    input logic tk, input logic fc);
    logic red, green, move_done, warn_done;
    green     = (light == 2'b01);
    red       = (light == 2'b00) || (light == 2'b11);
    move_done = tk && (t + 1 == MOVE_TIMEOUT);
    warn_done = tk && (t + 1 == WARN_DUR);
    if (s != 6 && lo && lc) return 6;
    case (s)
      0: return lo ? 1 : 5;
`ifdef GATE_WARN_EN
      1: return red ? 2 : 1;
`else
      1: return red ? 3 : 1;
`endif
      2: begin
        if (!red) return 1;
        if (warn_done) return 3;
        return 2;
      end
      3: begin
        if (ob || green) return 5;
        if (lc) return 4;
        if (move_done) return 6;
        return 3;
      end
      4: return green ? 5 : 4;
      5: begin
        if (lo) return 1;
        if (move_done) return 6;
        return 5;
      end
      6: return fc ? 0 : 6;
      default: return 0;
    endcase
  endfunction

  // Reference model advances on the same edges as the DUT
  always @(posedge clk or negedge rst_n) begin
    int nxt;
    if (!rst_n) begin
      m_state <= 0;
      m_ticks <= 0;
    end else begin
      nxt = model_next(m_state, m_ticks, light_state, lim_open, lim_closed,
                       obstacle, tick, fault_clr);
      m_state <= nxt;
      if (nxt != m_state) m_ticks <= 0;
      else if (tick && (m_state == 2 || m_state == 3 || m_state == 5)) m_ticks <= m_ticks + 1;
    end
  end

  // Compare DUT against the model on the falling edge, plus any pinned literal
  always @(negedge clk) begin
    logic [7:0] exp_v, got_v;
    exp_v = {3'(m_state), (m_state == 5), (m_state == 3), (m_state == 4),
             (m_state == 2), (m_state == 6)};
    got_v = {gate_state, motor_up, motor_down, gate_closed, warn, fault};
    checks = checks + 1;
    if (got_v === exp_v) passes = passes + 1;
    else $display("FAIL cycle_compare t=%0t: got state/up/dn/cl/wn/ft=%b required %b",
                  $time, got_v, exp_v);
    if (pin_valid) begin
      checks = checks + 1;
      if (gate_state === pin_state) passes = passes + 1;
      else $display("FAIL pin_state t=%0t: got %0d required %0d", $time, gate_state, pin_state);
    end
  end

  // Advance to just after the next falling edge
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Expect the given state at the next falling edge
  task automatic pin(input logic [2:0] s);
    pin_state = s;
    pin_valid = 1'b1;
    step();
    pin_valid = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1; step(); tick = 1'b0; step();
  endtask

  // From OPEN, drive RED and reach CLOSING
  task automatic go_closing();
    light_state = 2'b00;
    lim_open    = 1'b0;
`ifdef GATE_WARN_EN
    pin(3'd2);
    tick = 1'b1; pin(3'd2); tick = 1'b0; step();
    tick = 1'b1; pin(3'd3); tick = 1'b0;
`else
    pin(3'd3);
`endif
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; lim_open = 1'b1; lim_closed = 1'b0;
    obstacle = 1'b0; fault_clr = 1'b0; light_state = 2'b01;
    step(); step();
    pin(3'd0);
    // Release reset: INIT -> OPEN because the barrier is already up
    rst_n = 1'b1;
    pin(3'd1);

    // RED: close, 3 ticks of travel, reach CLOSED
    go_closing();
    pulse_tick(); pulse_tick(); pulse_tick();
    lim_closed = 1'b1;
    pin(3'd4);
    light_state = 2'b10;
    pin(3'd4);
    light_state = 2'b01;
    pin(3'd5);
    lim_closed = 1'b0;
    step();
    lim_open = 1'b1;
    pin(3'd1);

    // Obstacle beats lim_closed on the same cycle
    go_closing();
    obstacle = 1'b1; lim_closed = 1'b1;
    pin(3'd5);
    obstacle = 1'b0; lim_closed = 1'b0;
    pin(3'd5);
    lim_open = 1'b1;
    pin(3'd1);

    // Timeout in CLOSING on the 6th tick, then held fault_clr
    go_closing();
    for (int i = 0; i < MOVE_TIMEOUT - 1; i++) pulse_tick();
    tick = 1'b1;
    pin(3'd6);
    tick = 1'b0;
    pin(3'd6);
    fault_clr = 1'b1;
    pin(3'd0);
    pin(3'd5);
    fault_clr = 1'b0;
    lim_open = 1'b1;
    pin(3'd1);

    // Both limits high: FAULT, clearing re-enters FAULT while still inconsistent
    light_state = 2'b01;
    lim_closed = 1'b1;
    pin(3'd6);
    fault_clr = 1'b1;
    pin(3'd0);
    fault_clr = 1'b0;
    pin(3'd6);
    lim_closed = 1'b0;
    fault_clr = 1'b1;
    pin(3'd0);
    fault_clr = 1'b0;
    pin(3'd1);

`ifdef GATE_WARN_EN
    // GREEN during WARN returns to OPEN without motion
    light_state = 2'b00;
    pin(3'd2);
    tick = 1'b1; pin(3'd2); tick = 1'b0;
    light_state = 2'b01;
    pin(3'd1);
`endif

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      tick        = ($urandom_range(0, 3) == 0);
      light_state = 2'($urandom_range(0, 3));
      lim_open    = ($urandom_range(0, 9) == 0);
      lim_closed  = ($urandom_range(0, 9) == 0);
      obstacle    = ($urandom_range(0, 19) == 0);
      fault_clr   = ($urandom_range(0, 9) == 0);
      rst_n       = ($urandom_range(0, 299) != 0);
      step();
    end

    rst_n = 1'b1;
    step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/gate_ctrl.md
# gate_ctrl

Barrier-gate controller downstream of the traffic light FSM. Consumes the 2-bit light state and the shared 1-second `tick`, and drives a motorised barrier: it opens on GREEN, closes on RED and holds position on YELLOW. It reads open/closed limit switches and an obstacle sensor, reverses on obstruction, and latches a fault on motion timeout or inconsistent sensors.

## Interface
- `MOVE_TIMEOUT`, default 6: maximum ticks allowed in CLOSING/OPENING before FAULT; legal range 1..255.
- `WARN_DUR`, default 2: ticks of pre-close warning; used only when `GATE_WARN_EN` is defined; legal range 1..255.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tick`  in  1  one-cycle pulse, 1-second base, synchronous to `clk`.
- `light_state`  in  2  00 RED, 01 GREEN, 10 YELLOW; 11 is treated as RED.
- `lim_open`  in  1  barrier fully up; synchronous to `clk`.
- `lim_closed`  in  1  barrier fully down; synchronous to `clk`.
- `obstacle`  in  1  object under the barrier; synchronous to `clk`.
- `fault_clr`  in  1  one-cycle request to leave FAULT.
- `motor_up`  out  1  drive barrier up.
- `motor_down`  out  1  drive barrier down.
- `gate_closed`  out  1  high in CLOSED.
- `warn`  out  1  pre-close warning lamp/beeper.
- `fault`  out  1  high in FAULT.
- `gate_state`  out  3  current state encoding.

## Operation
- Moore machine. All outputs are decoded from the registered state. No input-to-output combinational path.
- State encodings: INIT 0, OPEN 1, WARN 2, CLOSING 3, CLOSED 4, OPENING 5, FAULT 6.
- Output decode:
  - `motor_up` = OPENING.
  - `motor_down` = CLOSING.
  - `warn` = WARN.
  - `gate_closed` = CLOSED.
  - `fault` = FAULT.
  - `motor_up` and `motor_down` are never high together.
- Transitions, evaluated every `clk`, first match wins:
  - Any state except FAULT: `lim_open && lim_closed` → FAULT.
  - INIT: `lim_open` → OPEN; otherwise → OPENING.
  - OPEN: light RED → WARN (with macro) or CLOSING (without).
  - WARN: light not RED → OPEN; WARN_DUR ticks elapsed → CLOSING.
  - CLOSING:
    - `obstacle` → OPENING.
    - light GREEN → OPENING.
    - `lim_closed` → CLOSED.
    - MOVE_TIMEOUT ticks elapsed → FAULT.
  - CLOSED: light GREEN → OPENING. YELLOW or RED holds.
  - OPENING:
    - `lim_open` → OPEN.
    - MOVE_TIMEOUT ticks elapsed → FAULT.
    - `obstacle` is ignored.
  - FAULT: `fault_clr` → INIT. Everything else is ignored.
- Tick counter:
  - 8-bit, cleared on every state change.
  - Increments on `tick` while in WARN, CLOSING or OPENING.
  - "N ticks elapsed" means `tick` is high while count == N−1.
  - Therefore the transition happens on exactly the N-th tick after entry.
- Simultaneous events:
  - A limit switch beats a timeout on the same cycle.
  - `obstacle` beats `lim_closed`.
  - A RED→GREEN change during WARN returns to OPEN; no motion occurs.

## Timing
- Reset: state INIT, counter 0. Outputs: `gate_state`=0, all other outputs 0.
- First edge after reset release: INIT → OPEN or OPENING.
- Latency from input change to output change: 1 `clk` (next state register, then decode).
- OPEN with RED persistent, without macro: `motor_down` rises 1 cycle after RED is first sampled.
- `fault_clr` held multiple cycles: INIT is entered once. If `fault_clr` is still high in INIT, it has no effect.
- Reset asserted mid-motion: motors drop asynchronously.

## Configuration
- `GATE_WARN_EN` defined:
  - WARN state exists.
  - `warn` is driven.
  - `WARN_DUR` is honoured.
- `GATE_WARN_EN` undefined:
  - OPEN goes directly to CLOSING.
  - `warn` is tied to 0.
  - Encoding 2 is unreachable.
  - `WARN_DUR` is unused.

## Structure
- `gate_pkg` holds:
  - Gate state localparams (INIT..FAULT).
  - Light encodings LIGHT_RED/GREEN/YELLOW, shared with the traffic light FSM.
- One sub-module, `gate_tick_cnt`: 8-bit tick counter with inputs clr, en, tick and target, and output done.
- The top level holds the state register, next-state logic and output decode.

## Test plan
- Reset with `lim_open`=1, light GREEN → next edge OPEN; `motor_up`=0; outputs all 0 during reset.
- Without macro, MOVE_TIMEOUT=6:
  - light RED → `motor_down`=1 one cycle later.
  - `lim_closed` after 3 ticks → CLOSED, `gate_closed`=1.
  - light GREEN → OPENING; `lim_open` → OPEN.
- CLOSING with `obstacle` pulsed while `lim_closed`=1 on the same cycle → OPENING, `motor_up`=1 next cycle.
- CLOSING with no limit switch for 6 ticks → FAULT on the 6th tick, motors 0.
  - `fault_clr` pulse → INIT, then OPENING.
- `lim_open`=`lim_closed`=1 in OPEN → FAULT next cycle. `fault_clr` while both are still high → INIT, then FAULT again.
- With `GATE_WARN_EN`, WARN_DUR=2:
  - RED → `warn`=1; CLOSING on the 2nd tick.
  - Repeat with GREEN after the 1st tick → OPEN; `motor_down` never asserts.
